spi_slave_device: RTL

SPI responder (slave), mode 0 (CPOL=0, CPHA=0), MSB first. It lets an external master (e.g. the mbed) clock words out of the FPGA and commands into it. It is the far-end counterpart of SPI_MASTER_DEVICE.
- All SPI pins are oversampled in the SYS_CLK domain (40 MHz).
- The parallel side uses a valid/ready transmit handshake and a FIN-pulsed receive word.
- The block sits between a FIFO read port and GPIO pins.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_slave_device_if.sv | 30 +++
 rtl/sync_edge.sv | 32 +++
 rtl/spi_slave_device.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI responder: bus mode, FSM encoding and master timing limits.
package spi_pkg;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    // SYS_CLK periods the master must leave between CSbar fall and the first SCK rise
    localparam int MIN_CS_SETUP = 5;

    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/spi_slave_device_if.sv
// Pin-level and parallel-side signals of the SPI responder, grouped as one bundle.
interface spi_slave_device_if #(
    parameter int BITS = 16
);

    logic            SCK;
    logic            CSbar;
    logic            MOSI;
    logic            MISO;
    logic            MISO_OE;
    logic [BITS-1:0] DATA_MISO;
    logic            TX_VALID;
    logic            TX_READY;
    logic [BITS-1:0] DATA_MOSI;
    logic            FIN;
    logic            BUSY;
    logic            FRAME_ERR;
    logic            UNDERRUN;

    modport slave (
        input  SCK, CSbar, MOSI, DATA_MISO, TX_VALID,
        output MISO, MISO_OE, TX_READY, DATA_MOSI, FIN, BUSY, FRAME_ERR, UNDERRUN
    );

    modport master (
        output SCK, CSbar, MOSI, DATA_MISO, TX_VALID,
        input  MISO, MISO_OE, TX_READY, DATA_MOSI, FIN, BUSY, FRAME_ERR, UNDERRUN
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a third stage for edge detection.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic SYS_CLK,
    input  logic reset,
    input  logic pin_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], pin_in};
    end

    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_device.sv
// SPI mode-0 responder: oversamples SCK/CSbar/MOSI in SYS_CLK and streams words both ways.
//   state    | meaning
//   IDLE     | CSbar high, MISO tri-stated, waiting for CSbar fall
//   LOAD     | one cycle: fetch first word (or IDLE_WORD) and drive its MSB
//   SHIFT    | frame active: sample MOSI on SCK rise, advance MISO on SCK fall
module spi_slave_device
    import spi_pkg::*;
#(
    parameter int              BITS      = 16,
    parameter logic [BITS-1:0] IDLE_WORD = '0
) (
    input logic               SYS_CLK,
    input logic               reset,
    spi_slave_device_if.slave sif
);

    localparam int              CNT_W          = cnt_width(BITS);
    localparam logic [CNT_W-1:0] LAST_BIT      = CNT_W'(BITS - 1);
    localparam logic            SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

    logic sck_rise, sck_fall, sck_lvl_unused;
    logic cs_rise, cs_fall, cs_lvl_unused;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.RST_VAL(SPI_CPOL)) u_sync_sck (
        .SYS_CLK (SYS_CLK),
        .reset   (reset),
        .pin_in  (sif.SCK),
        .level   (sck_lvl_unused),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );

    sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .SYS_CLK (SYS_CLK),
        .reset   (reset),
        .pin_in  (sif.CSbar),
        .level   (cs_lvl_unused),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .SYS_CLK (SYS_CLK),
        .reset   (reset),
        .pin_in  (sif.MOSI),
        .level   (mosi_lvl),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    logic sample_evt, drive_evt;
    assign sample_evt = SAMPLE_ON_RISE ? sck_rise : sck_fall;
    assign drive_evt  = SAMPLE_ON_RISE ? sck_fall : sck_rise;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BITS-2:0]  shift_in_q, shift_in_d;
    // MSB of the outgoing word lives in miso_q; shift_out_q holds the bits still to send
    logic [BITS-2:0]  shift_out_q, shift_out_d;
    logic             miso_q, miso_d;
    logic             miso_oe_q, miso_oe_d;
    logic [BITS-1:0]  data_mosi_q, data_mosi_d;
    logic             fin_q, fin_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             underrun_q, underrun_d;
    logic             armed_q, armed_d;

    logic             do_load;
    logic             tx_ready;
    logic [BITS-1:0]  load_word;
    logic [BITS-1:0]  rx_word;

    assign load_word = sif.TX_VALID ? sif.DATA_MISO : IDLE_WORD;
    assign rx_word   = {shift_in_q, mosi_lvl};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        data_mosi_d = data_mosi_q;
        fin_d       = 1'b0;
        busy_d      = busy_q;
        frame_err_d = frame_err_q;
        underrun_d  = underrun_q;
        armed_d     = armed_q;
        do_load     = 1'b0;
        tx_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_oe_d = 1'b0;
                busy_d    = 1'b0;
                if (cs_fall) begin
                    state_d     = ST_LOAD;
                    frame_err_d = 1'b0;
                    underrun_d  = 1'b0;
                end
            end

            ST_LOAD: begin
                do_load   = 1'b1;
                miso_oe_d = 1'b1;
                busy_d    = 1'b1;
                bit_cnt_d = '0;
                armed_d   = 1'b0;
                state_d   = ST_SHIFT;
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    miso_oe_d = 1'b0;
                    busy_d    = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (sample_evt) begin
                    shift_in_d = rx_word[BITS-2:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        data_mosi_d = rx_word;
                        fin_d       = 1'b1;
                        bit_cnt_d   = '0;
                        armed_d     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                // A same-cycle final-bit rise completes the word before CSbar ends the frame
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    miso_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    armed_d   = 1'b0;
                    if (bit_cnt_d != '0) begin
                        frame_err_d = 1'b1;
                    end
                end else if (drive_evt) begin
                    if (armed_q) begin
                        do_load = 1'b1;
                        armed_d = 1'b0;
                    end else begin
                        miso_d      = shift_out_q[BITS-2];
                        shift_out_d = shift_out_q << 1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_load) begin
            shift_out_d = load_word[BITS-2:0];
            miso_d      = load_word[BITS-1];
            if (sif.TX_VALID) begin
                tx_ready = 1'b1;
            end else begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            data_mosi_q <= '0;
            fin_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            underrun_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            data_mosi_q <= data_mosi_d;
            fin_q       <= fin_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            underrun_q  <= underrun_d;
            armed_q     <= armed_d;
        end
    end

    assign sif.MISO      = miso_q;
    assign sif.MISO_OE   = miso_oe_q;
    assign sif.TX_READY  = tx_ready;
    assign sif.DATA_MOSI = data_mosi_q;
    assign sif.FIN       = fin_q;
    assign sif.BUSY      = busy_q;
    assign sif.FRAME_ERR = frame_err_q;
    assign sif.UNDERRUN  = underrun_q;

endmodule
